// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-to-UART drain.
// State encoding and frame constants used by the top and the bench.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Per-bit cycle counter: restarts on clear, pulses tick on the last cycle of a bit.
// pre_tick marks the cycle before tick so callers can register end-of-bit outputs.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [W-1:0] count;

    assign tick     = (count == W'(CLKS_PER_BIT - 1));
    assign pre_tick = (count == W'(CLKS_PER_BIT - 2));

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops bytes from the FIFO and serialises them as 8N1 (or 8E1) UART frames.
// All outputs are registered; the baud counter is held at zero outside the bit states.
module fifo_uart_drain
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_rdata,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    state_t     state;
    logic [7:0] shreg;
    logic       par;
    logic [2:0] bit_idx;
    logic       clear;
    logic       tick;
    logic       pre_tick;

    assign clear = (state == S_IDLE) || (state == S_POP) || (state == S_WAIT);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tx         <= IDLE_LEVEL;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            bit_idx    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (en && !fifo_empty) begin
                        state      <= S_POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_POP: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    shreg <= fifo_rdata;
                    par   <= ^fifo_rdata;
                    tx    <= 1'b0;
                    state <= S_START;
                end
                S_START: begin
                    if (tick) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(FRAME_DATA_BITS - 1)) begin
                            if (PARITY_EN) begin
                                state <= S_PARITY;
                                tx    <= par;
                            end else begin
                                state <= S_STOP;
                                tx    <= IDLE_LEVEL;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        state <= S_STOP;
                        tx    <= IDLE_LEVEL;
                    end
                end
                S_STOP: begin
                    // tx_done lands on the final stop cycle
                    if (pre_tick) begin
                        tx_done <= 1'b1;
                    end
                    if (tick) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Randomised bench for fifo_uart_drain: FIFO model plus frame-level reference.
// Two instances cover PARITY_EN=0 and PARITY_EN=1 at CLKS_PER_BIT=4.
module tb_fifo_uart_drain;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en0 = 1'b0;
    logic       en1 = 1'b0;
    logic       empty0 = 1'b1;
    logic       empty1 = 1'b1;
    logic [7:0] rdata0 = 8'h00;
    logic [7:0] rdata1 = 8'h00;
    logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         rdcnt0 = 0;
    int         donecnt0 = 0;
    int         under0 = 0;
    int         under1 = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_uart_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u0 (
        .clk(clk), .rst(rst), .en(en0), .fifo_empty(empty0),
        .fifo_rd_en(rd0), .fifo_rdata(rdata0),
        .tx(tx0), .busy(busy0), .tx_done(done0)
    );

    fifo_uart_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u1 (
        .clk(clk), .rst(rst), .en(en1), .fifo_empty(empty1),
        .fifo_rd_en(rd1), .fifo_rdata(rdata1),
        .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    // FIFO model: data valid only the cycle after a read, noise otherwise
    always @(posedge clk) begin
        logic [7:0] b;
        if (rd0) begin
            rdcnt0++;
            if (q0.size() > 0) begin
                b = q0.pop_front();
                rdata0 <= b;
            end else begin
                under0++;
            end
        end else begin
            rdata0 <= 8'($urandom);
        end
        if (rd1) begin
            if (q1.size() > 0) begin
                b = q1.pop_front();
                rdata1 <= b;
            end else begin
                under1++;
            end
        end else begin
            rdata1 <= 8'($urandom);
        end
        if (done0) donecnt0++;
        empty0 <= (q0.size() == 0);
        empty1 <= (q1.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int d);
        return d != 0 ? tx1 : tx0;
    endfunction

    function automatic logic rd_of(input int d);
        return d != 0 ? rd1 : rd0;
    endfunction

    function automatic logic busy_of(input int d);
        return d != 0 ? busy1 : busy0;
    endfunction

    function automatic logic done_of(input int d);
        return d != 0 ? done1 : done0;
    endfunction

    // Expected line level of slot s in a frame for byte b
    function automatic logic slot_level(input logic [7:0] b, input int s, input bit par);
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        if (par && s == 9) return ^b;
        return 1'b1;
    endfunction

    // act: 0 none, 1 drop en at act_slot, 2 assert reset at act_slot
    task automatic frame(input int d, input logic [7:0] b, input int act_slot,
                         input int act, output int waited);
        int nb;
        bit par;
        par = (d != 0);
        nb = par ? 11 : 10;
        waited = 0;
        @(negedge clk);
        while (rd_of(d) !== 1'b1 && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        chk("pop_seen", 32'(rd_of(d)), 32'd1);
        chk("pop_tx", 32'(tx_of(d)), 32'd1);
        @(negedge clk);
        chk("wait_rd", 32'(rd_of(d)), 32'd0);
        chk("wait_tx", 32'(tx_of(d)), 32'd1);
        for (int s = 0; s < nb; s++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                chk($sformatf("tx_b%02h_s%0d", b, s), 32'(tx_of(d)),
                    32'(slot_level(b, s, par)));
                chk("tx_done", 32'(done_of(d)), 32'(s == nb - 1 && c == CPB - 1));
                chk("busy", 32'(busy_of(d)), 32'd1);
                chk("rd_quiet", 32'(rd_of(d)), 32'd0);
                if (act == 1 && s == act_slot && c == 0) begin
                    if (d != 0) en1 = 1'b0; else en0 = 1'b0;
                end
                if (act == 2 && s == act_slot && c == 0) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk("abort_tx", 32'(tx_of(d)), 32'd1);
                    chk("abort_busy", 32'(busy_of(d)), 32'd0);
                    chk("abort_rd", 32'(rd_of(d)), 32'd0);
                    rst = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        chk("idle_tx", 32'(tx_of(d)), 32'd1);
        chk("idle_busy", 32'(busy_of(d)), 32'd0);
    endtask

    initial begin
        int         w;
        int         bad;
        int         rd_base;
        int         done_base;
        logic [7:0] rnd[8];

        @(negedge clk);
        chk("rst_tx0", 32'(tx0), 32'd1);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_rd0", 32'(rd0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_tx1", 32'(tx1), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        en0 = 1'b1;
        en1 = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || rd0 !== 1'b0) bad++;
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || rd1 !== 1'b0) bad++;
        end
        chk("idle_empty", 32'(bad), 32'd0);

        q0.push_back(8'hA5);
        frame(0, 8'hA5, -1, 0, w);

        q1.push_back(8'h07);
        frame(1, 8'h07, -1, 0, w);
        q1.push_back(8'h03);
        frame(1, 8'h03, -1, 0, w);

        foreach (rnd[i]) begin
            rnd[i] = 8'($urandom);
            q1.push_back(rnd[i]);
        end
        foreach (rnd[i]) begin
            frame(1, rnd[i], -1, 0, w);
            if (i > 0) chk("rand_gap", 32'(w), 32'd0);
        end

        en0 = 1'b0;
        for (int i = 1; i <= 64; i++) q0.push_back(8'(i));
        repeat (3) @(negedge clk);
        rd_base = rdcnt0;
        done_base = donecnt0;
        en0 = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            frame(0, 8'(i), -1, 0, w);
            if (i > 1) chk("burst_gap", 32'(w), 32'd0);
        end
        repeat (30) @(negedge clk);
        chk("burst_reads", 32'(rdcnt0 - rd_base), 32'd64);
        chk("burst_dones", 32'(donecnt0 - done_base), 32'd64);
        chk("burst_under", 32'(under0), 32'd0);

        q0.push_back(8'hC3);
        q0.push_back(8'h5A);
        frame(0, 8'hC3, 4, 1, w);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (rd0 !== 1'b0 || busy0 !== 1'b0) bad++;
        end
        chk("en_drop_quiet", 32'(bad), 32'd0);
        chk("en_drop_left", 32'(q0.size()), 32'd1);

        q0.push_back(8'h96);
        en0 = 1'b1;
        frame(0, 8'h5A, 6, 2, w);
        frame(0, 8'h96, -1, 0, w);
        chk("after_rst_w", 32'(w), 32'd0);
        repeat (10) @(negedge clk);
        chk("underflow0", 32'(under0), 32'd0);
        chk("underflow1", 32'(under1), 32'd0);
        chk("drained", 32'(q0.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
